// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic sub_diff_bit(input logic x, input logic y, input logic br);
        return x ^ y ^ br;
    endfunction

    // Full-subtractor borrow-out.
    function automatic logic sub_borrow_bit(input logic x, input logic y, input logic br);
        return (~x & y) | (~(x ^ y) & br);
    endfunction

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] a_sh_r, b_sh_r, part_r, diff_r;
    logic [CW-1:0]    cnt_r;
    logic             br_r, borrow_r, ready_r, busy_r, done_r;
    logic             d_s, br_next_s, last_s;
    logic [WIDTH-1:0] part_next_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    // Bit-slice datapath for the current SHIFT step.
    always_comb begin
        d_s         = sub_diff_bit(a_sh_r[0], b_sh_r[0], br_r);
        br_next_s   = sub_borrow_bit(a_sh_r[0], b_sh_r[0], br_r);
        part_next_s = {d_s, part_r[WIDTH-1:1]};
        last_s      = (cnt_r == CW'(WIDTH - 1));
    end

    // Next-state logic; DONE always lasts a single cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_SHIFT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_SHIFT;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, status flags and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            part_r   <= '0;
            cnt_r    <= '0;
            br_r     <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == S_IDLE);
            busy_r  <= (state_next_s == S_SHIFT);
            done_r  <= (state_next_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bin;
                        cnt_r  <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    part_r <= part_next_s;
                    br_r   <= br_next_s;
                    cnt_r  <= cnt_r + CW'(1);
                    // Publish only on the final bit so diff/borrow are never partial.
                    if (last_s) begin
                        diff_r   <= part_next_s;
                        borrow_r <= br_next_s;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r    <= br_r ^ br_next_s;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = ready_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_r;
`endif

endmodule
